// File: rtl/obstacle_engine.sv
// Multi-obstacle sprite engine: holds NUM_OBS rectangular obstacles, moves
// them horizontally on a frame-derived step tick and streams erase/redraw
// pixels to the VGA adapter over a valid/ready plot interface.
module obstacle_engine #(
    parameter int          NUM_OBS   = 4,
    parameter int          OBJ_W     = 4,
    parameter int          OBJ_H     = 4,
    parameter int          X_START   = 10,
    parameter int          X_LIMIT   = 100,
    parameter int          STEP      = 1,
    parameter int          WRAP      = 0,
    parameter int          FRAME_DIV = 833333,
    parameter int          MOVE_DIV  = 15,
    parameter logic [2:0]  COLOUR    = 3'd2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               spawn,
    input  logic [6:0]         spawn_y,
    output logic               plot,
    input  logic               plot_ready,
    output logic [7:0]         x,
    output logic [6:0]         y,
    output logic [2:0]         colour,
    output logic [NUM_OBS-1:0] active_mask,
    output logic               pass_pulse,
    output logic               busy
);
    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int CW = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;
    localparam int RW = (OBJ_H > 1) ? $clog2(OBJ_H) : 1;
    // Slot index must also be able to hold NUM_OBS, the end-of-pass value.
    localparam int IW = $clog2(NUM_OBS + 1);

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_ERASE = 3'd1,
        S_MOVE  = 3'd2,
        S_DRAW  = 3'd3,
        S_NEXT  = 3'd4,
        S_SPAWN = 3'd5
    } state_t;

    state_t               state_r, state_n;
    logic [IW-1:0]        idx_r, idx_n;
    logic [CW-1:0]        col_r, col_n;
    logic [RW-1:0]        row_r, row_n;
    logic [7:0]           pos_x_r [NUM_OBS];
    logic [7:0]           pos_x_n [NUM_OBS];
    logic [6:0]           pos_y_r [NUM_OBS];
    logic [6:0]           pos_y_n [NUM_OBS];
    logic [NUM_OBS-1:0]   active_r, active_n;
    logic                 step_pend_r, spawn_pend_r;
    logic [6:0]           spawn_y_r;
    logic [FW-1:0]        frame_cnt_r;
    logic [MW-1:0]        move_cnt_r;
    logic                 plot_r, pass_r, busy_r;
    logic [7:0]           x_r;
    logic [6:0]           y_r;
    logic [2:0]           colour_r;

    logic                 frame_tick_s, step_tick_s, accept_s, last_pix_s;
    logic                 step_clr_s, spawn_clr_s, pass_n;
    logic                 cur_active_s, free_found_s;
    logic [7:0]           cur_x_s, ox_s;
    logic [6:0]           oy_s;
    logic [IW-1:0]        free_idx_s;
    logic [8:0]           nx_s;
    logic                 plot_n, busy_n;
    logic [7:0]           x_n;
    logic [6:0]           y_n;
    logic [2:0]           colour_n;

    assign frame_tick_s = enable && (frame_cnt_r == FW'(FRAME_DIV - 1));
    assign step_tick_s  = frame_tick_s && (move_cnt_r == MW'(MOVE_DIV - 1));
    assign accept_s     = plot_r && plot_ready;
    assign last_pix_s   = (col_r == CW'(OBJ_W - 1)) && (row_r == RW'(OBJ_H - 1));

    // Frame and step prescalers, frozen while enable is low
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt_r <= {FW{1'b0}};
            move_cnt_r  <= {MW{1'b0}};
        end else if (enable) begin
            frame_cnt_r <= frame_tick_s ? {FW{1'b0}} : frame_cnt_r + FW'(1);
            if (frame_tick_s) begin
                move_cnt_r <= step_tick_s ? {MW{1'b0}} : move_cnt_r + MW'(1);
            end
        end
    end

    // Pending step / spawn requests; a new tick wins over a same-cycle clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_pend_r  <= 1'b0;
            spawn_pend_r <= 1'b0;
            spawn_y_r    <= 7'd0;
        end else begin
            step_pend_r <= (step_clr_s ? 1'b0 : step_pend_r) | step_tick_s;
            if (spawn_clr_s) begin
                spawn_pend_r <= 1'b0;
            end else if (spawn && !spawn_pend_r) begin
                spawn_pend_r <= 1'b1;
                spawn_y_r    <= spawn_y;
            end
        end
    end

    // Look up the addressed slot and the lowest free slot
    always_comb begin
        cur_x_s      = 8'd0;
        cur_active_s = 1'b0;
        free_found_s = 1'b0;
        free_idx_s   = {IW{1'b0}};
        for (int k = 0; k < NUM_OBS; k++) begin
            cur_x_s      = (idx_r == IW'(k)) ? pos_x_r[k] : cur_x_s;
            cur_active_s = (idx_r == IW'(k)) ? active_r[k] : cur_active_s;
        end
        for (int k = NUM_OBS - 1; k >= 0; k--) begin
            free_found_s = active_r[k] ? free_found_s : 1'b1;
            free_idx_s   = active_r[k] ? free_idx_s : IW'(k);
        end
    end

    // Next-state logic: FSM, raster counters and slot storage updates
    always_comb begin
        state_n     = state_r;
        idx_n       = idx_r;
        col_n       = col_r;
        row_n       = row_r;
        pos_x_n     = pos_x_r;
        pos_y_n     = pos_y_r;
        active_n    = active_r;
        step_clr_s  = 1'b0;
        spawn_clr_s = 1'b0;
        pass_n      = 1'b0;
        nx_s        = {1'b0, cur_x_s} + 9'(STEP);

        // Raster counter advances only on an accepted pixel
        if (accept_s) begin
            if (col_r == CW'(OBJ_W - 1)) begin
                col_n = {CW{1'b0}};
                row_n = last_pix_s ? {RW{1'b0}} : row_r + RW'(1);
            end else begin
                col_n = col_r + CW'(1);
            end
        end else begin
            col_n = col_r;
        end

        case (state_r)
            S_WAIT: begin
                if (spawn_pend_r) begin
                    spawn_clr_s = 1'b1;
                    if (free_found_s) begin
                        for (int k = 0; k < NUM_OBS; k++) begin
                            if (free_idx_s == IW'(k)) begin
                                active_n[k] = 1'b1;
                                pos_x_n[k]  = 8'(X_START);
                                pos_y_n[k]  = spawn_y_r;
                            end else begin
                                active_n[k] = active_r[k];
                            end
                        end
                        idx_n   = free_idx_s;
                        state_n = S_SPAWN;
                    end else begin
                        state_n = S_WAIT;
                    end
                end else if (step_pend_r) begin
                    step_clr_s = 1'b1;
                    idx_n      = {IW{1'b0}};
                    state_n    = S_NEXT;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_NEXT: begin
                if (idx_r >= IW'(NUM_OBS)) begin
                    state_n = S_WAIT;
                end else if (cur_active_s) begin
                    state_n = S_ERASE;
                end else begin
                    idx_n = idx_r + IW'(1);
                end
            end
            S_ERASE: begin
                state_n = (accept_s && last_pix_s) ? S_MOVE : S_ERASE;
            end
            S_MOVE: begin
                for (int k = 0; k < NUM_OBS; k++) begin
                    if (idx_r == IW'(k)) begin
                        if (nx_s > 9'(X_LIMIT)) begin
                            pos_x_n[k]  = (WRAP != 0) ? 8'(X_START) : pos_x_r[k];
                            active_n[k] = (WRAP != 0);
                        end else begin
                            pos_x_n[k] = nx_s[7:0];
                        end
                    end else begin
                        pos_x_n[k] = pos_x_r[k];
                    end
                end
                if ((nx_s > 9'(X_LIMIT)) && (WRAP == 0)) begin
                    pass_n  = 1'b1;
                    idx_n   = idx_r + IW'(1);
                    state_n = S_NEXT;
                end else begin
                    state_n = S_DRAW;
                end
            end
            S_DRAW: begin
                if (accept_s && last_pix_s) begin
                    idx_n   = idx_r + IW'(1);
                    state_n = S_NEXT;
                end else begin
                    state_n = S_DRAW;
                end
            end
            S_SPAWN: begin
                state_n = (accept_s && last_pix_s) ? S_WAIT : S_SPAWN;
            end
            default: begin
                state_n = S_WAIT;
            end
        endcase
    end

    // Pixel outputs precomputed from next-cycle state so they leave a register
    always_comb begin
        plot_n = (state_n == S_ERASE) || (state_n == S_DRAW) || (state_n == S_SPAWN);
        busy_n = (state_n != S_WAIT);
        ox_s   = 8'd0;
        oy_s   = 7'd0;
        for (int k = 0; k < NUM_OBS; k++) begin
            ox_s = (idx_n == IW'(k)) ? pos_x_n[k] : ox_s;
            oy_s = (idx_n == IW'(k)) ? pos_y_n[k] : oy_s;
        end
        if (plot_n) begin
            x_n      = ox_s + 8'(col_n);
            y_n      = oy_s + 7'(row_n);
            colour_n = (state_n == S_ERASE) ? 3'd0 : COLOUR;
        end else begin
            x_n      = x_r;
            y_n      = y_r;
            colour_n = colour_r;
        end
    end

    // FSM state, slot index, raster counters and slot storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= S_WAIT;
            idx_r    <= {IW{1'b0}};
            col_r    <= {CW{1'b0}};
            row_r    <= {RW{1'b0}};
            active_r <= {NUM_OBS{1'b0}};
            for (int k = 0; k < NUM_OBS; k++) begin
                pos_x_r[k] <= 8'd0;
                pos_y_r[k] <= 7'd0;
            end
        end else begin
            state_r  <= state_n;
            idx_r    <= idx_n;
            col_r    <= col_n;
            row_r    <= row_n;
            active_r <= active_n;
            pos_x_r  <= pos_x_n;
            pos_y_r  <= pos_y_n;
        end
    end

    // Registered output stage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            plot_r   <= 1'b0;
            x_r      <= 8'd0;
            y_r      <= 7'd0;
            colour_r <= 3'd0;
            pass_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            plot_r   <= plot_n;
            x_r      <= x_n;
            y_r      <= y_n;
            colour_r <= colour_n;
            pass_r   <= pass_n;
            busy_r   <= busy_n;
        end
    end

    assign plot        = plot_r;
    assign x           = x_r;
    assign y           = y_r;
    assign colour      = colour_r;
    assign active_mask = active_r;
    assign pass_pulse  = pass_r;
    assign busy        = busy_r;
endmodule
